sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_arb_pkg.sv | 29 ++
 rtl/sdram_port_arbiter_if.sv | 44 ++++
 rtl/sdram_port_arbiter_refresh_scheduler.sv | 61 ++++++
 rtl/sdram_port_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM port arbiter: owner encoding,
// arbiter FSM states, datapath widths and parameter defaults.
package sdram_arb_pkg;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 8;
  localparam int DEBT_W = 3;

  localparam int REFRESH_INTERVAL_DEF = 390;
  localparam int REFRESH_URGENT_DEF   = 4;
  localparam int VIDEO_MAX_WAIT_DEF   = 16;

  // Refresh debt saturates here; one more interval wrap flags an overflow.
  localparam logic [DEBT_W-1:0] DEBT_MAX = 3'd7;

  typedef enum logic [1:0] {
    GRANT_NONE    = 2'd0,
    GRANT_BUS     = 2'd1,
    GRANT_VIDEO   = 2'd2,
    GRANT_REFRESH = 2'd3
  } grant_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Requester and SDRAM-controller signals of the arbiter, bundled.
// master: the arbiter's view (serves bus/video, drives the SDRAM controller).
// slave:  the surrounding system's view of the same wires.
interface sdram_port_arbiter_if;

  logic                              bus_req;
  logic                              bus_we;
  logic [sdram_arb_pkg::ADDR_W-1:0]  bus_address;
  logic [sdram_arb_pkg::DATA_W-1:0]  bus_wdata;
  logic [sdram_arb_pkg::DATA_W-1:0]  bus_rdata;
  logic                              bus_ack;

  logic                              video_req;
  logic [sdram_arb_pkg::ADDR_W-1:0]  video_address;
  logic [sdram_arb_pkg::DATA_W-1:0]  video_rdata;
  logic                              video_ack;

  logic                              mem_req;
  logic                              mem_we;
  logic                              mem_refresh;
  logic [sdram_arb_pkg::ADDR_W-1:0]  mem_address;
  logic [sdram_arb_pkg::DATA_W-1:0]  mem_wdata;
  logic [sdram_arb_pkg::DATA_W-1:0]  mem_rdata;
  logic                              mem_ack;

  modport master (
    input  bus_req, bus_we, bus_address, bus_wdata,
    output bus_rdata, bus_ack,
    input  video_req, video_address,
    output video_rdata, video_ack,
    output mem_req, mem_we, mem_refresh, mem_address, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    output bus_req, bus_we, bus_address, bus_wdata,
    input  bus_rdata, bus_ack,
    output video_req, video_address,
    input  video_rdata, video_ack,
    input  mem_req, mem_we, mem_refresh, mem_address, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/sdram_port_arbiter_refresh_scheduler.sv
// Refresh bookkeeping: a free-running interval counter adds one unit of
// refresh debt per interval, each completed refresh pays one back. Debt
// saturates at DEBT_MAX; a wrap while saturated sets a sticky overflow.
module refresh_scheduler
  import sdram_arb_pkg::*;
#(
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              refresh_done,
  output logic [DEBT_W-1:0] debt,
  output logic              overflow
);

  localparam int CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);

  logic [CNT_W-1:0] interval_count;
  logic             wrap;

  assign wrap = (interval_count == CNT_LAST);

  // Interval counter: counts 0..REFRESH_INTERVAL-1 and wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      interval_count <= '0;
    end else if (wrap) begin
      interval_count <= '0;
    end else begin
      interval_count <= interval_count + CNT_W'(1);
    end
  end

  // Debt tracking: a wrap and a completion in the same cycle cancel out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      debt     <= '0;
      overflow <= 1'b0;
    end else begin
      case ({wrap, refresh_done})
        2'b10: begin
          if (debt == DEBT_MAX) begin
            overflow <= 1'b1;
          end else begin
            debt <= debt + DEBT_W'(1);
          end
        end
        2'b01: begin
          if (debt != '0) begin
            debt <= debt - DEBT_W'(1);
          end
        end
        default: begin
          debt <= debt;
        end
      endcase
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Arbitrates CPU/DMA bus, video fetch and auto-refresh onto a single SDRAM
// controller request port. Strobes are captured into per-requester pending
// registers; a strobe arriving in an IDLE cycle can be granted the same cycle.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
  parameter int REFRESH_URGENT   = REFRESH_URGENT_DEF,
  parameter int VIDEO_MAX_WAIT   = VIDEO_MAX_WAIT_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  sdram_port_arbiter_if.master arb,
  output logic [1:0]           grant,
  output logic                 refresh_overflow
);

  localparam int AGE_W = $clog2(VIDEO_MAX_WAIT + 1);
  localparam logic [AGE_W-1:0]  AGE_MAX    = AGE_W'(VIDEO_MAX_WAIT);
  localparam logic [DEBT_W-1:0] DEBT_URGNT = DEBT_W'(REFRESH_URGENT);

  state_t state, state_next;
  grant_t owner, pick;

  // Pending means "captured and not yet completed", so it also covers the
  // time the requester is being served; a new strobe is then dropped.
  logic              bus_pend, bus_we_q;
  logic [ADDR_W-1:0] bus_address_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic              video_pend;
  logic [ADDR_W-1:0] video_address_q;
  logic [AGE_W-1:0]  video_age;

  logic              bus_take, bus_cand, bus_eff_we;
  logic [ADDR_W-1:0] bus_eff_address, video_eff_address;
  logic [DATA_W-1:0] bus_eff_wdata;
  logic              video_take, video_cand, video_aged, video_in_service;
  logic              decide, mem_done, refresh_done;
  logic [DEBT_W-1:0] debt;

  assign bus_take          = arb.bus_req && !bus_pend;
  assign bus_cand          = bus_pend || bus_take;
  assign bus_eff_we        = bus_pend ? bus_we_q      : arb.bus_we;
  assign bus_eff_address   = bus_pend ? bus_address_q : arb.bus_address;
  assign bus_eff_wdata     = bus_pend ? bus_wdata_q   : arb.bus_wdata;

  assign video_take        = arb.video_req && !video_pend;
  assign video_cand        = video_pend || video_take;
  assign video_eff_address = video_pend ? video_address_q : arb.video_address;
  assign video_aged        = video_pend && (video_age == AGE_MAX);
  assign video_in_service  = (state == ST_BUSY) && (owner == GRANT_VIDEO);

  assign decide       = (state == ST_IDLE) && (pick != GRANT_NONE);
  assign mem_done     = (state == ST_BUSY) && arb.mem_ack;
  assign refresh_done = mem_done && (owner == GRANT_REFRESH);

  assign grant = owner;

  refresh_scheduler #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL)
  ) u_refresh (
    .clock        (clock),
    .reset        (reset),
    .refresh_done (refresh_done),
    .debt         (debt),
    .overflow     (refresh_overflow)
  );

  // Priority pick: urgent refresh > aged video > bus > video > due refresh.
  always_comb begin
    pick = GRANT_NONE;
    if (debt >= DEBT_URGNT) begin
      pick = GRANT_REFRESH;
    end else if (video_aged) begin
      pick = GRANT_VIDEO;
    end else if (bus_cand) begin
      pick = GRANT_BUS;
    end else if (video_cand) begin
      pick = GRANT_VIDEO;
    end else if (debt != '0) begin
      pick = GRANT_REFRESH;
    end else begin
      pick = GRANT_NONE;
    end
  end

  // FSM next state: IDLE leaves only with a candidate, BUSY waits for mem_ack.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: state_next = (pick != GRANT_NONE) ? ST_BUSY : ST_IDLE;
      ST_BUSY: state_next = arb.mem_ack ? ST_DONE : ST_BUSY;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pending capture for both requesters; cleared when their transfer is acked.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus_pend        <= 1'b0;
      bus_we_q        <= 1'b0;
      bus_address_q   <= '0;
      bus_wdata_q     <= '0;
      video_pend      <= 1'b0;
      video_address_q <= '0;
    end else begin
      if (mem_done && (owner == GRANT_BUS)) begin
        bus_pend <= 1'b0;
      end else if (bus_take) begin
        bus_pend      <= 1'b1;
        bus_we_q      <= arb.bus_we;
        bus_address_q <= arb.bus_address;
        bus_wdata_q   <= arb.bus_wdata;
      end
      if (mem_done && (owner == GRANT_VIDEO)) begin
        video_pend <= 1'b0;
      end else if (video_take) begin
        video_pend      <= 1'b1;
        video_address_q <= arb.video_address;
      end
    end
  end

  // Video wait age: counts waiting cycles up to VIDEO_MAX_WAIT, cleared on grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      video_age <= '0;
    end else if (decide && (pick == GRANT_VIDEO)) begin
      video_age <= '0;
    end else if (video_pend && !video_in_service && (video_age != AGE_MAX)) begin
      video_age <= video_age + AGE_W'(1);
    end
  end

  // Registered SDRAM request, owner, completion pulses and read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      arb.mem_req     <= 1'b0;
      arb.mem_we      <= 1'b0;
      arb.mem_refresh <= 1'b0;
      arb.mem_address <= '0;
      arb.mem_wdata   <= '0;
      arb.bus_ack     <= 1'b0;
      arb.bus_rdata   <= '0;
      arb.video_ack   <= 1'b0;
      arb.video_rdata <= '0;
      owner           <= GRANT_NONE;
    end else begin
      arb.bus_ack   <= 1'b0;
      arb.video_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          owner <= pick;
          if (decide) begin
            arb.mem_req     <= 1'b1;
            arb.mem_refresh <= (pick == GRANT_REFRESH);
            case (pick)
              GRANT_BUS: begin
                arb.mem_we      <= bus_eff_we;
                arb.mem_address <= bus_eff_address;
                arb.mem_wdata   <= bus_eff_wdata;
              end
              GRANT_VIDEO: begin
                arb.mem_we      <= 1'b0;
                arb.mem_address <= video_eff_address;
                arb.mem_wdata   <= '0;
              end
              default: begin
                arb.mem_we      <= 1'b0;
                arb.mem_address <= '0;
                arb.mem_wdata   <= '0;
              end
            endcase
          end
        end
        ST_BUSY: begin
          if (arb.mem_ack) begin
            arb.mem_req <= 1'b0;
            case (owner)
              GRANT_BUS: begin
                arb.bus_ack <= 1'b1;
                if (!arb.mem_we) begin
                  arb.bus_rdata <= arb.mem_rdata;
                end
              end
              GRANT_VIDEO: begin
                arb.video_ack   <= 1'b1;
                arb.video_rdata <= arb.mem_rdata;
              end
              default: begin
                arb.bus_ack <= 1'b0;
              end
            endcase
          end
        end
        ST_DONE: begin
          owner <= GRANT_NONE;
        end
        default: begin
          owner <= GRANT_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed testbench for sdram_port_arbiter with a short refresh interval (8).
// Cycle 0 of each scenario is the first cycle after reset is released.
module tb_sdram_port_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] grant;
  logic       refresh_overflow;

  int         tests_run    = 0;
  int         tests_failed = 0;

  int         mem_lat  = 2;
  bit         mem_hold = 1'b0;
  logic [7:0] mem_data = 8'h00;
  int         mem_cnt  = 0;

  sdram_port_arbiter_if arb_if();

  sdram_port_arbiter #(
    .REFRESH_INTERVAL (8),
    .REFRESH_URGENT   (4),
    .VIDEO_MAX_WAIT   (16)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .arb              (arb_if),
    .grant            (grant),
    .refresh_overflow (refresh_overflow)
  );

  always #5 clock = ~clock;

  // SDRAM controller model: acks after mem_lat request cycles unless held.
  initial begin
    arb_if.mem_ack   = 1'b0;
    arb_if.mem_rdata = 8'h00;
    forever begin
      @(posedge clock);
      #2;
      if (arb_if.mem_req) mem_cnt++;
      else mem_cnt = 0;
      arb_if.mem_ack   = arb_if.mem_req && !mem_hold && (mem_cnt >= mem_lat);
      arb_if.mem_rdata = mem_data;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    arb_if.bus_req = 1'b0;
    arb_if.bus_we = 1'b0;
    arb_if.bus_address = 22'h0;
    arb_if.bus_wdata = 8'h00;
    arb_if.video_req = 1'b0;
    arb_if.video_address = 22'h0;
    mem_hold = 1'b0;
    mem_lat = 2;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if (arb_if.mem_req !== 1'b0 || arb_if.mem_we !== 1'b0 || arb_if.mem_refresh !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mem_ctl: req/we/ref=%b%b%b want 000", arb_if.mem_req, arb_if.mem_we, arb_if.mem_refresh);
    end
    tests_run++;
    if (arb_if.mem_address !== 22'h0 || arb_if.mem_wdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mem_data: addr=%h wdata=%h want 0", arb_if.mem_address, arb_if.mem_wdata);
    end
    tests_run++;
    if (grant !== 2'd0 || refresh_overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_grant: grant=%0d ovf=%b want 0 0", grant, refresh_overflow);
    end
    tests_run++;
    if (arb_if.bus_ack !== 1'b0 || arb_if.video_ack !== 1'b0 ||
        arb_if.bus_rdata !== 8'h00 || arb_if.video_rdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_acks: acks=%b%b rdata=%h/%h want 0", arb_if.bus_ack, arb_if.video_ack,
               arb_if.bus_rdata, arb_if.video_rdata);
    end
  endtask

  // Bus read at cycle 0, ack at cycle 3: mem_req 1..3, bus_ack and data at 4.
  task automatic test_bus_read();
    logic exp_req, exp_ack;
    apply_reset();
    mem_lat = 3;
    mem_data = 8'hA5;
    arb_if.bus_req = 1'b1;
    arb_if.bus_we = 1'b0;
    arb_if.bus_address = 22'h012345;
    for (int c = 1; c <= 5; c++) begin
      tick();
      arb_if.bus_req = 1'b0;
      exp_req = (c <= 3);
      exp_ack = (c == 4);
      tests_run++;
      if (arb_if.mem_req !== exp_req || arb_if.bus_ack !== exp_ack) begin
        tests_failed++;
        $display("FAIL bus_read_c%0d: req=%b ack=%b want %b %b", c, arb_if.mem_req, arb_if.bus_ack, exp_req, exp_ack);
      end
      if (c == 1) begin
        tests_run++;
        if (grant !== 2'd1 || arb_if.mem_we !== 1'b0 || arb_if.mem_refresh !== 1'b0 ||
            arb_if.mem_address !== 22'h012345) begin
          tests_failed++;
          $display("FAIL bus_read_issue: grant=%0d we=%b ref=%b addr=%h want 1 0 0 012345",
                   grant, arb_if.mem_we, arb_if.mem_refresh, arb_if.mem_address);
        end
      end
      if (c == 4) begin
        tests_run++;
        if (arb_if.bus_rdata !== 8'hA5 || grant !== 2'd1) begin
          tests_failed++;
          $display("FAIL bus_read_data: rdata=%h grant=%0d want a5 1", arb_if.bus_rdata, grant);
        end
      end
      if (c == 5) begin
        tests_run++;
        if (grant !== 2'd0) begin
          tests_failed++;
          $display("FAIL bus_read_idle: grant=%0d want 0", grant);
        end
      end
    end
  endtask

  // Simultaneous bus write and video read: bus first, video right after.
  task automatic test_bus_then_video();
    logic [8:1] exp_req   = 8'b0011_0011;
    logic [8:1] exp_back  = 8'b0000_0100;
    logic [8:1] exp_vack  = 8'b0100_0000;
    int         exp_grant [8] = '{1, 1, 1, 0, 2, 2, 2, 0};
    apply_reset();
    mem_lat = 2;
    mem_data = 8'h3C;
    arb_if.bus_req = 1'b1;
    arb_if.bus_we = 1'b1;
    arb_if.bus_address = 22'h2ABCDE;
    arb_if.bus_wdata = 8'h5A;
    arb_if.video_req = 1'b1;
    arb_if.video_address = 22'h1F00F0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      arb_if.bus_req = 1'b0;
      arb_if.video_req = 1'b0;
      tests_run++;
      if (arb_if.mem_req !== exp_req[c] || int'(grant) != exp_grant[c-1] ||
          arb_if.bus_ack !== exp_back[c] || arb_if.video_ack !== exp_vack[c]) begin
        tests_failed++;
        $display("FAIL bv_c%0d: req=%b grant=%0d back=%b vack=%b want %b %0d %b %b", c, arb_if.mem_req, grant,
                 arb_if.bus_ack, arb_if.video_ack, exp_req[c], exp_grant[c-1], exp_back[c], exp_vack[c]);
      end
      if (c == 1) begin
        tests_run++;
        if (arb_if.mem_we !== 1'b1 || arb_if.mem_wdata !== 8'h5A || arb_if.mem_address !== 22'h2ABCDE) begin
          tests_failed++;
          $display("FAIL bv_write_issue: we=%b wdata=%h addr=%h want 1 5a 2abcde",
                   arb_if.mem_we, arb_if.mem_wdata, arb_if.mem_address);
        end
      end
      if (c == 3) begin
        tests_run++;
        if (arb_if.bus_rdata !== 8'h00) begin
          tests_failed++;
          $display("FAIL bv_write_rdata: rdata=%h want 00", arb_if.bus_rdata);
        end
      end
      if (c == 5) begin
        tests_run++;
        if (arb_if.mem_we !== 1'b0 || arb_if.mem_address !== 22'h1F00F0) begin
          tests_failed++;
          $display("FAIL bv_video_issue: we=%b addr=%h want 0 1f00f0", arb_if.mem_we, arb_if.mem_address);
        end
      end
      if (c == 7) begin
        tests_run++;
        if (arb_if.video_rdata !== 8'h3C) begin
          tests_failed++;
          $display("FAIL bv_video_rdata: rdata=%h want 3c", arb_if.video_rdata);
        end
      end
    end
  endtask

  // Back-to-back bus strobes starve video until its age hits 16.
  task automatic test_video_aging();
    int first_video = -1;
    int bus_acks    = 0;
    int bus_before  = -1;
    apply_reset();
    mem_lat = 2;
    arb_if.bus_req = 1'b1;
    arb_if.bus_we = 1'b0;
    arb_if.bus_address = 22'h000100;
    arb_if.video_req = 1'b1;
    arb_if.video_address = 22'h000200;
    for (int c = 1; c <= 24; c++) begin
      tick();
      arb_if.bus_req = 1'b0;
      arb_if.video_req = 1'b0;
      if (arb_if.bus_ack === 1'b1) begin
        bus_acks++;
        arb_if.bus_req = 1'b1;
      end
      if (first_video < 0 && arb_if.mem_req === 1'b1 && grant === 2'd2) begin
        first_video = c;
        bus_before = bus_acks;
      end
    end
    arb_if.bus_req = 1'b0;
    tests_run++;
    if (first_video != 21) begin
      tests_failed++;
      $display("FAIL aging_grant_cycle: got %0d want 21", first_video);
    end
    tests_run++;
    if (bus_before != 5) begin
      tests_failed++;
      $display("FAIL aging_bus_count: got %0d want 5", bus_before);
    end
  endtask

  // Refresh stuck 40 cycles: debt passes 4, so refresh beats aged video and bus.
  task automatic test_refresh_urgent();
    apply_reset();
    mem_hold = 1'b1;
    for (int c = 1; c <= 51; c++) begin
      tick();
      arb_if.bus_req = 1'b0;
      arb_if.video_req = 1'b0;
      if (c == 9) begin
        tests_run++;
        if (arb_if.mem_req !== 1'b1 || grant !== 2'd3 || arb_if.mem_refresh !== 1'b1) begin
          tests_failed++;
          $display("FAIL ref_first: req=%b grant=%0d ref=%b want 1 3 1", arb_if.mem_req, grant, arb_if.mem_refresh);
        end
      end
      if (c == 20) begin
        arb_if.bus_req = 1'b1;
        arb_if.bus_address = 22'h000111;
        arb_if.video_req = 1'b1;
        arb_if.video_address = 22'h000222;
      end
      if (c == 47) begin
        tests_run++;
        if (arb_if.mem_req !== 1'b1 || grant !== 2'd3) begin
          tests_failed++;
          $display("FAIL ref_held: req=%b grant=%0d want 1 3", arb_if.mem_req, grant);
        end
      end
      if (c == 48) mem_hold = 1'b0;
      if (c == 49) begin
        tests_run++;
        if (arb_if.mem_req !== 1'b0 || grant !== 2'd3 || arb_if.bus_ack !== 1'b0 || arb_if.video_ack !== 1'b0) begin
          tests_failed++;
          $display("FAIL ref_done: req=%b grant=%0d acks=%b%b want 0 3 00", arb_if.mem_req, grant,
                   arb_if.bus_ack, arb_if.video_ack);
        end
      end
      if (c == 51) begin
        tests_run++;
        if (arb_if.mem_req !== 1'b1 || grant !== 2'd3 || arb_if.mem_refresh !== 1'b1) begin
          tests_failed++;
          $display("FAIL ref_urgent: req=%b grant=%0d ref=%b want 1 3 1", arb_if.mem_req, grant, arb_if.mem_refresh);
        end
      end
    end
  endtask

  // Debt saturates at 7 (cycle 56); the wrap in cycle 63 sets the sticky flag.
  task automatic test_overflow();
    apply_reset();
    mem_hold = 1'b1;
    for (int c = 1; c <= 66; c++) begin
      tick();
      if (c == 63) begin
        tests_run++;
        if (refresh_overflow !== 1'b0) begin
          tests_failed++;
          $display("FAIL ovf_early: got %b want 0", refresh_overflow);
        end
      end
      if (c == 64 || c == 66) begin
        tests_run++;
        if (refresh_overflow !== 1'b1) begin
          tests_failed++;
          $display("FAIL ovf_set_c%0d: got %b want 1", c, refresh_overflow);
        end
      end
      if (c == 65) mem_hold = 1'b0;
    end
  endtask

  // Reset in the middle of a refresh: no ack, and debt/interval restart from 0.
  task automatic test_reset_abort();
    logic exp_req;
    apply_reset();
    tests_run++;
    if (refresh_overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_ovf_clear: got %b want 0", refresh_overflow);
    end
    mem_hold = 1'b1;
    for (int c = 1; c <= 20; c++) tick();
    tests_run++;
    if (arb_if.mem_req !== 1'b1 || grant !== 2'd3) begin
      tests_failed++;
      $display("FAIL abort_pre: req=%b grant=%0d want 1 3", arb_if.mem_req, grant);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (arb_if.mem_req !== 1'b0 || grant !== 2'd0 || arb_if.bus_ack !== 1'b0 || arb_if.video_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_now: req=%b grant=%0d acks=%b%b want 0 0 00", arb_if.mem_req, grant,
               arb_if.bus_ack, arb_if.video_ack);
    end
    tick();
    reset = 1'b0;
    mem_hold = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      exp_req = (c == 9);
      tests_run++;
      if (arb_if.mem_req !== exp_req || arb_if.bus_ack !== 1'b0 || arb_if.video_ack !== 1'b0) begin
        tests_failed++;
        $display("FAIL abort_after_c%0d: req=%b acks=%b%b want %b 00", c, arb_if.mem_req,
                 arb_if.bus_ack, arb_if.video_ack, exp_req);
      end
    end
    tests_run++;
    if (grant !== 2'd3) begin
      tests_failed++;
      $display("FAIL abort_refresh_grant: grant=%0d want 3", grant);
    end
  endtask

  initial begin
    arb_if.bus_req = 1'b0;
    arb_if.bus_we = 1'b0;
    arb_if.bus_address = 22'h0;
    arb_if.bus_wdata = 8'h00;
    arb_if.video_req = 1'b0;
    arb_if.video_address = 22'h0;
    test_reset();
    test_bus_read();
    test_bus_then_video();
    test_video_aging();
    test_refresh_urgent();
    test_overflow();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
